// File: rtl/alu_bist_sequencer.sv
// Built-in self-test driver for the 16-bit accumulator ALU: walks a fixed
// vector table, drives each vector, waits for settling and grades the result.
module alu_bist_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic        alu_iszero,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [2:0]  first_fail_idx
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FINISH} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [15:0] a_q, b_q;
    logic [2:0]  ctrl_q;
    logic        busy_q, done_q, pass_q;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [2:0]  ffi_q;

    logic [15:0] vec_a, vec_b, exp_out;
    logic [2:0]  vec_ctrl;
    logic        exp_zero, exp_ovf, ovf_chk, mismatch;

    // Vector table: operands, op select and the golden response for each index.
    always_comb begin
        vec_ctrl = 3'd0;
        vec_a    = 16'h0004;
        vec_b    = 16'h0005;
        exp_out  = 16'h0000;
        exp_zero = 1'b0;
        exp_ovf  = 1'b0;
        ovf_chk  = 1'b0;
        case (idx_q)
            3'd0: begin vec_ctrl = 3'd0; exp_out = 16'h0005; end
            3'd1: begin vec_ctrl = 3'd1; exp_out = 16'h0009; ovf_chk = 1'b1; end
            3'd2: begin vec_ctrl = 3'd2; exp_out = 16'hFFFF; ovf_chk = 1'b1; end
            3'd3: begin vec_ctrl = 3'd3; exp_out = 16'h0001; ovf_chk = 1'b1; end
            3'd4: begin vec_ctrl = 3'd4; exp_out = 16'h0005; end
            3'd5: begin vec_ctrl = 3'd5; exp_out = 16'h0004; end
            3'd6: begin
                vec_ctrl = 3'd1; vec_a = 16'h0000; vec_b = 16'h0000;
                exp_out  = 16'h0000; exp_zero = 1'b1; ovf_chk = 1'b1;
            end
            default: begin
                vec_ctrl = 3'd1; vec_a = 16'h7FFF; vec_b = 16'h0001;
                exp_out  = 16'h8000; exp_ovf = 1'b1; ovf_chk = 1'b1;
            end
        endcase
    end

    assign mismatch = (alu_out != exp_out) || (alu_iszero != exp_zero) ||
                      (ovf_chk && (alu_overflow != exp_ovf));
    assign fcnt_d   = (fcnt_q == 4'hF) ? fcnt_q : fcnt_q + 4'd1;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            ctrl_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fcnt_q  <= 4'd0;
            ffi_q   <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fcnt_q  <= 4'd0;
                        ffi_q   <= 3'd0;
                        pass_q  <= 1'b0;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    a_q     <= vec_a;
                    b_q     <= vec_b;
                    ctrl_q  <= vec_ctrl;
                    cnt_q   <= SETTLE_LD;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_q <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        fcnt_q <= fcnt_d;
                        if (fcnt_q == 4'd0) ffi_q <= idx_q;
                    end
                    if (idx_q == 3'd7 || (STOP_ON_FAIL && mismatch)) begin
                        state_q <= FINISH;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= DRIVE;
                    end
                end
                FINISH: begin
                    // fail_count already includes the final CHECK here.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (fcnt_q == 4'd0);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_ctrl       = ctrl_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fcnt_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: three parameter variants beside a fault-injectable
// ALU model, graded every cycle against a run-level timing model.
module tb_alu_bist_sequencer;

    logic CLK = 1'b0;
    logic Reset_n = 1'b0;
    logic start = 1'b0;
    always #5 CLK = ~CLK;

    logic [15:0] a_w [3];
    logic [15:0] b_w [3];
    logic [15:0] o_w [3];
    logic [2:0]  c_w [3];
    logic        z_w [3];
    logic        v_w [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        pass_w [3];
    logic [3:0]  fc_w [3];
    logic [2:0]  ffi_w [3];

    int          fault = 0;
    logic [15:0] fmask = 16'h0;
    logic [2:0]  fctrl = 3'd0;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [2:0]  TC [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1};
    localparam logic [15:0] TA [8] = '{16'h4, 16'h4, 16'h4, 16'h4, 16'h4, 16'h4, 16'h0, 16'h7FFF};
    localparam logic [15:0] TB [8] = '{16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h0, 16'h1};
    localparam logic [15:0] TO [8] = '{16'h5, 16'h9, 16'hFFFF, 16'h1, 16'h5, 16'h4, 16'h0, 16'h8000};
    localparam bit TZ [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    localparam bit TV [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    localparam bit TK [8] = '{0, 1, 1, 1, 0, 0, 1, 1};

    // ALU behaviour; fm: 1 add+1, 2 overflow stuck 0, 3 xor mask on op fc, 4 zero inverted on op fc
    function automatic logic [17:0] alu_f(logic [15:0] a, logic [15:0] b, logic [2:0] c,
                                          int fm, logic [15:0] mask, logic [2:0] fc);
        logic [15:0] r;
        logic ov, z;
        r = 16'h0;
        ov = 1'b0;
        case (c)
            3'd0: r = b;
            3'd1: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd2: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd3: begin r = b - a; ov = (a[15] != b[15]) && (r[15] != b[15]); end
            3'd4: r = a | b;
            3'd5: r = a & b;
            3'd6: r = a << b[3:0];
            default: r = a >> b[3:0];
        endcase
        if (fm == 1 && c == 3'd1) r = r + 16'd1;
        if (fm == 2) ov = 1'b0;
        if (fm == 3 && c == fc) r = r ^ mask;
        z = (r == 16'h0);
        if (fm == 4 && c == fc) z = !z;
        return {r, z, ov};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        alu_bist_sequencer #(
            .SETTLE_CYCLES(gi == 2 ? 3 : 1),
            .STOP_ON_FAIL (gi == 1)
        ) u_dut (
            .CLK           (CLK),
            .Reset_n       (Reset_n),
            .start         (start),
            .alu_a         (a_w[gi]),
            .alu_b         (b_w[gi]),
            .alu_ctrl      (c_w[gi]),
            .alu_out       (o_w[gi]),
            .alu_iszero    (z_w[gi]),
            .alu_overflow  (v_w[gi]),
            .busy          (busy_w[gi]),
            .done          (done_w[gi]),
            .pass          (pass_w[gi]),
            .fail_count    (fc_w[gi]),
            .first_fail_idx(ffi_w[gi])
        );
        assign {o_w[gi], z_w[gi], v_w[gi]} = alu_f(a_w[gi], b_w[gi], c_w[gi], fault, fmask, fctrl);
    end

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Run-level model: t = cycles since the accepting edge, mm = per-vector verdicts.
    int t_m [3] = '{0, 0, 0};
    bit st_m [3] = '{0, 0, 0};
    int n_m [3] = '{8, 8, 8};
    int hold_m [3] = '{-1, -1, -1};
    bit mm [3][8];

    function automatic int per(int i);
        return (i == 2 ? 3 : 1) + 2;
    endfunction

    function automatic int len_m(int i);
        return n_m[i] * per(i) + 1;
    endfunction

    function automatic bit all_idle();
        bit r = 1'b1;
        for (int i = 0; i < 3; i++)
            if (st_m[i] && t_m[i] < len_m(i)) r = 1'b0;
        return r;
    endfunction

    task automatic plan_run(int i);
        logic [17:0] r;
        bit found = 1'b0;
        n_m[i] = 8;
        for (int k = 0; k < 8; k++) begin
            r = alu_f(TA[k], TB[k], TC[k], fault, fmask, fctrl);
            mm[i][k] = (r[17:2] != TO[k]) || (r[1] != TZ[k]) || (TK[k] && r[0] != TV[k]);
            if (i == 1 && mm[i][k] && !found) begin
                n_m[i] = k + 1;
                found = 1'b1;
            end
        end
    endtask

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 3; i++) begin
                t_m[i] = 0; st_m[i] = 1'b0; hold_m[i] = -1; n_m[i] = 8;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (start && (!st_m[i] || t_m[i] >= len_m(i))) begin
                    if (st_m[i]) hold_m[i] = n_m[i] - 1;
                    plan_run(i);
                    t_m[i] = 0;
                    st_m[i] = 1'b1;
                end else begin
                    t_m[i]++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            int P, L, nd, nc, v, fc, ff;
            bit eb, ed, ep;
            P = per(i); L = len_m(i);
            nd = 0; nc = 0; fc = 0; ff = 0; eb = 0; ed = 0; ep = 0;
            if (st_m[i]) begin
                nd = (t_m[i] >= 1) ? (t_m[i] - 1) / P + 1 : 0;
                if (nd > n_m[i]) nd = n_m[i];
                nc = t_m[i] / P;
                if (nc > n_m[i]) nc = n_m[i];
                for (int k = 0; k < nc; k++)
                    if (mm[i][k]) begin
                        if (fc == 0) ff = k;
                        fc++;
                    end
                eb = t_m[i] < L;
                ed = t_m[i] == L;
                ep = (t_m[i] >= L) && (fc == 0);
            end
            v = (nd > 0) ? nd - 1 : hold_m[i];
            chk("alu_a", i, a_w[i], v >= 0 ? TA[v] : 16'h0);
            chk("alu_b", i, b_w[i], v >= 0 ? TB[v] : 16'h0);
            chk("alu_ctrl", i, c_w[i], v >= 0 ? TC[v] : 3'd0);
            chk("busy", i, busy_w[i], eb);
            chk("done", i, done_w[i], ed);
            chk("pass", i, pass_w[i], ep);
            chk("fail_count", i, fc_w[i], fc > 15 ? 15 : fc);
            chk("first_fail_idx", i, ffi_w[i], ff);
        end
    end

    task automatic go(int len);
        start = 1'b1;
        repeat (len) @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && !all_idle(); k++) @(negedge CLK);
        n_chk++;
        if (!all_idle()) begin
            n_fail++;
            $display("FAIL wait_idle: run still busy after 200 cycles");
        end
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        chk("rst_busy", 0, busy_w[0], 0);
        chk("rst_a", 0, a_w[0], 0);

        // clean run
        go(1);
        chk("s1_busy_c0", 0, busy_w[0], 1);
        repeat (24) @(negedge CLK);
        chk("s1_done_c24", 0, done_w[0], 0);
        @(negedge CLK);
        chk("s1_done_c25", 0, done_w[0], 1);
        chk("s1_pass", 0, pass_w[0], 1);
        chk("s1_fc", 0, fc_w[0], 0);
        chk("s1_ffi", 0, ffi_w[0], 0);
        wait_idle();

        // add returns sum+1
        fault = 1;
        go(1);
        repeat (7) @(negedge CLK);
        chk("s2_stop_done_c7", 1, done_w[1], 1);
        chk("s2_stop_fc", 1, fc_w[1], 1);
        chk("s2_stop_ffi", 1, ffi_w[1], 1);
        repeat (18) @(negedge CLK);
        chk("s2_done_c25", 0, done_w[0], 1);
        chk("s2_fc", 0, fc_w[0], 3);
        chk("s2_ffi", 0, ffi_w[0], 1);
        chk("s2_pass", 0, pass_w[0], 0);
        wait_idle();

        // overflow stuck at 0
        fault = 2;
        go(1);
        repeat (25) @(negedge CLK);
        chk("s3_fc", 0, fc_w[0], 1);
        chk("s3_ffi", 0, ffi_w[0], 7);
        chk("s3_pass", 0, pass_w[0], 0);
        wait_idle();

        // re-pulse while busy, SETTLE_CYCLES=3 instance
        fault = 0;
        go(1);
        for (int c = 1; c <= 41; c++) begin
            @(negedge CLK);
            if (c == 40) chk("s4_done_c40", 2, done_w[2], 0);
            if (c == 41) begin
                chk("s4_done_c41", 2, done_w[2], 1);
                chk("s4_pass", 2, pass_w[2], 1);
                chk("s4_fc", 2, fc_w[2], 0);
            end
            start = (c == 4 || c == 15 || c == 30);
        end
        start = 1'b0;
        wait_idle();

        // reset during vector 3 SETTLE
        go(1);
        repeat (10) @(negedge CLK);
        #2 Reset_n = 1'b0;
        #1;
        chk("s5_rst_a", 0, a_w[0], 0);
        chk("s5_rst_ctrl", 0, c_w[0], 0);
        chk("s5_rst_busy", 0, busy_w[0], 0);
        chk("s5_rst_done", 0, done_w[0], 0);
        @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        go(1);
        repeat (25) @(negedge CLK);
        chk("s5_done_c25", 0, done_w[0], 1);
        chk("s5_pass", 0, pass_w[0], 1);
        wait_idle();

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            int rst_at;
            fault = $urandom_range(0, 4);
            fmask = 16'($urandom);
            fctrl = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            go($urandom_range(1, 3));
            rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : -1;
            for (int c = 1; c <= 30; c++) begin
                @(negedge CLK);
                if (c == rst_at) begin
                    start = 1'b0;
                    #2 Reset_n = 1'b0;
                    @(negedge CLK);
                    Reset_n = 1'b1;
                    break;
                end
                start = ($urandom_range(0, 5) == 0);
            end
            start = 1'b0;
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bist_sequencer.md
Name: alu_bist_sequencer

Overview:
Sequential built-in self-test driver for the 16-bit accumulator ALU. On request, it steps through a fixed internal table of operation vectors. For each vector it drives the ALU operand and control inputs, waits for the result to settle, and compares ALUOut, iszero and Overflow against expected values. It sits beside the ALU in the datapath (muxed onto ALU inputs during test) and reports pass/fail status to the control unit or a debug LED.

Parameters:
SETTLE_CYCLES, 1, cycles to wait after driving a vector before sampling ALU outputs (legal 1..15)
STOP_ON_FAIL, 0, 1 = end run at first mismatching vector; 0 = run all vectors

Ports:
CLK  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
start  input  1  run request; sampled only in IDLE
alu_a  output  16  operand a to ALU
alu_b  output  16  operand b to ALU
alu_ctrl  output  3  ALU op select
alu_out  input  16  ALU result (ALUOut)
alu_iszero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at end of run
pass  output  1  sticky: 1 if last completed run had zero mismatches
fail_count  output  4  mismatching vectors in last run (saturates at 15)
first_fail_idx  output  3  index of first mismatching vector; 0 if none

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - all outputs 0;
  - FSM to IDLE;
  - vector index and settle counter cleared.
  - Reset mid-run aborts immediately; no done pulse.
- ALU op encoding: 0 pass b, 1 a+b, 2 a-b, 3 b-a, 4 a|b, 5 a&b, 6 sll, 7 srl.
- Vector table (idx: ctrl, a, b -> out, zero, ovf, ovf_checked):
  - 0: 0, 0004, 0005 -> 0005, 0, -, no
  - 1: 1, 0004, 0005 -> 0009, 0, 0, yes
  - 2: 2, 0004, 0005 -> FFFF, 0, 0, yes
  - 3: 3, 0004, 0005 -> 0001, 0, 0, yes
  - 4: 4, 0004, 0005 -> 0005, 0, -, no
  - 5: 5, 0004, 0005 -> 0004, 0, -, no
  - 6: 1, 0000, 0000 -> 0000, 1, 0, yes
  - 7: 1, 7FFF, 0001 -> 8000, 0, 1, yes
- Vector mismatch definition: alu_out != exp_out, OR alu_iszero != exp_zero, OR (ovf_checked AND alu_overflow != exp_ovf).
- FSM states: IDLE, DRIVE, SETTLE, CHECK, FINISH.
  - IDLE: busy=0. When start=1, clear fail_count, first_fail_idx and pass, set idx=0, go to DRIVE.
  - DRIVE (1 cycle): register table[idx] onto alu_a, alu_b and alu_ctrl; busy=1; load settle counter with SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter each cycle; go to CHECK when it reaches 0 (exactly SETTLE_CYCLES cycles).
  - CHECK (1 cycle): sample and compare the ALU outputs.
    - On mismatch: fail_count += 1 (saturating); if this is the first failure, first_fail_idx = idx.
    - If idx==7, or (STOP_ON_FAIL and mismatch): go to FINISH.
    - Otherwise: idx += 1 and go to DRIVE.
  - FINISH (1 cycle): done=1; pass = (fail_count==0 including the current CHECK result); busy=0 on the next cycle; go to IDLE.
- Per vector: 2+SETTLE_CYCLES cycles. A full clean run with default parameters: start sampled at edge 0, done high during cycle 25.
- alu_a, alu_b and alu_ctrl hold the last vector after a run. They return to 0 only on reset.
- pass, fail_count and first_fail_idx hold until the next accepted start.
- start while busy is ignored; no queuing. start held high through FINISH restarts a run on the first IDLE cycle.
- idx never wraps past 7.

Test Plan:
- Correct behavioural ALU model, start pulse -> busy asserts the next cycle; done pulse in cycle 25; pass=1, fail_count=0, first_fail_idx=0.
- Faulty ALU (add returns sum+1), STOP_ON_FAIL=0 -> vectors 1, 6 and 7 mismatch; fail_count=3, first_fail_idx=1, pass=0.
- Same fault, STOP_ON_FAIL=1 -> done after vector 1 CHECK (cycle 7), fail_count=1, first_fail_idx=1.
- Overflow flag stuck at 0 -> only vector 7 fails; fail_count=1, first_fail_idx=7; vectors 0, 4 and 5 unaffected by the flag.
- start re-pulsed while busy, and SETTLE_CYCLES=3 -> no restart; done in cycle 41; results unchanged from a single run.
- Reset_n low during vector 3 SETTLE -> all outputs 0 asynchronously, no done pulse; a fresh start then passes normally.
